// File: rtl/line_buf_ctrl_pkg.sv
// Shared types and constants for the convolution engine's line buffer write side.
package conveng_pkg;

   localparam int NUM_ROWS = 4;
   localparam int WIN_ROWS = 3;

   typedef logic [1:0] row_idx_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } lb_state_t;

endpackage

// File: rtl/line_buf_ctrl_if.sv
// Pixel stream, row-memory write port and window status for line_buf_ctrl.
// Handshake: a pixel transfers on a rising edge where in_valid && in_ready; in_ready never depends on in_valid.
interface line_buf_ctrl_if #(
   parameter int IMG_W  = 32,
   parameter int DATA_W = 8
);
   import conveng_pkg::*;

   localparam int COL_W = $clog2(IMG_W);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_sof;
   logic              wr_en;
   row_idx_t          wr_row;
   logic [COL_W-1:0]  wr_col;
   logic [DATA_W-1:0] wr_data;
   row_idx_t          base;
   logic              win_valid;
   logic              win_done;
   logic [2:0]        rows_full;
   logic              err;
   lb_state_t         dbg_state;

   modport slave (
      input  in_valid, in_data, in_sof, win_done,
      output in_ready, wr_en, wr_row, wr_col, wr_data,
             base, win_valid, rows_full, err, dbg_state
   );

   modport master (
      output in_valid, in_data, in_sof, win_done,
      input  in_ready, wr_en, wr_row, wr_col, wr_data,
             base, win_valid, rows_full, err, dbg_state
   );

endinterface

// File: rtl/lb_col_cnt.sv
// Column counter for one raster row; clr together with inc means the pixel at column 0 was just taken.
module lb_col_cnt #(
   parameter int IMG_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     inc,
   output logic [$clog2(IMG_W)-1:0] col,
   output logic                     wrap
);

   localparam int COL_W = $clog2(IMG_W);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

   logic [COL_W-1:0] col_q;
   logic [COL_W-1:0] col_d;

   always_comb begin
      wrap  = inc && !clr && (col_q == LAST_COL);
      col_d = col_q;
      if (clr) begin
         col_d = inc ? COL_W'(1) : '0;
      end else if (inc) begin
         col_d = wrap ? '0 : col_q + COL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q <= '0;
      end else begin
         col_q <= col_d;
      end
   end

   assign col = col_q;

endmodule

// File: rtl/line_buf_ctrl.sv
// Write-side controller for the four-row circular line buffer: row write strobes,
// resident-row occupancy and the oldest-row index handed to the row rotator.
module line_buf_ctrl
   import conveng_pkg::*;
#(
   parameter int IMG_W  = 32,
   parameter int DATA_W = 8
) (
   input logic        clk,
   input logic        rst_n,
   line_buf_ctrl_if.slave bus
);

   localparam int COL_W = $clog2(IMG_W);

   lb_state_t         state_q, state_d;
   row_idx_t          base_q, base_d;
   logic [2:0]        rows_full_q, rows_full_d;
   logic              err_q, err_d;
   logic              wr_en_q, wr_en_d;
   row_idx_t          wr_row_q, wr_row_d;
   logic [COL_W-1:0]  wr_col_q, wr_col_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   logic             in_ready;
   logic             win_valid;
   logic             accept;
   logic             sof_acc;
   logic             pix_acc;
   logic             row_done;
   logic             wd_ok;
   logic [COL_W-1:0] col;
   row_idx_t         wr_ptr;

   assign accept  = bus.in_valid && in_ready;
   assign sof_acc = accept && bus.in_sof;
   assign pix_acc = accept && !bus.in_sof && (state_q != IDLE);
   assign wr_ptr  = base_q + row_idx_t'(rows_full_q[1:0]);

   lb_col_cnt #(.IMG_W(IMG_W)) u_col_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (sof_acc),
      .inc   (sof_acc || pix_acc),
      .col   (col),
      .wrap  (row_done)
   );

   // Occupancy: an SOF restarts the buffer at the current write row and swallows any win_done.
   always_comb begin
      base_d      = base_q;
      rows_full_d = rows_full_q;
      err_d       = err_q;
      wd_ok       = bus.win_done && (rows_full_q >= 3'(WIN_ROWS));
      if (sof_acc) begin
         base_d      = wr_ptr;
         rows_full_d = '0;
         if ((state_q != IDLE) && (col != '0)) begin
            err_d = 1'b1;
         end
      end else begin
         rows_full_d = rows_full_q + {2'b00, row_done} - {2'b00, wd_ok};
         base_d      = base_q + row_idx_t'(wd_ok);
         if (bus.win_done && !wd_ok) begin
            err_d = 1'b1;
         end
      end
   end

   always_comb begin
      wr_en_d   = sof_acc || pix_acc;
      wr_row_d  = wr_row_q;
      wr_col_d  = wr_col_q;
      wr_data_d = wr_data_q;
      if (wr_en_d) begin
         wr_row_d  = wr_ptr;
         wr_col_d  = sof_acc ? '0 : col;
         wr_data_d = bus.in_data;
      end
   end

   always_comb begin
      state_d = state_q;
      if (sof_acc) begin
         state_d = FILL;
      end else if (state_q != IDLE) begin
         state_d = (rows_full_d >= 3'(WIN_ROWS)) ? RUN : FILL;
      end
   end

   always_comb begin
      in_ready  = !((state_q == RUN) && (rows_full_q == 3'(NUM_ROWS)));
      win_valid = (state_q == RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         base_q      <= '0;
         rows_full_q <= '0;
         err_q       <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_row_q    <= '0;
         wr_col_q    <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         rows_full_q <= rows_full_d;
         err_q       <= err_d;
         wr_en_q     <= wr_en_d;
         wr_row_q    <= wr_row_d;
         wr_col_q    <= wr_col_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.win_valid = win_valid;
   assign bus.base      = base_q;
   assign bus.rows_full = rows_full_q;
   assign bus.err       = err_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_row    = wr_row_q;
   assign bus.wr_col    = wr_col_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Bench for line_buf_ctrl: directed scenarios plus random traffic against an occupancy-level model.
module tb_line_buf_ctrl;
   import conveng_pkg::*;

   localparam int IMG_W  = 32;
   localparam int DATA_W = 8;
   localparam int COL_W  = $clog2(IMG_W);
   localparam int W      = 2 + COL_W + DATA_W;

   logic clk;
   logic rst_n;

   line_buf_ctrl_if #(.IMG_W(IMG_W), .DATA_W(DATA_W)) lb ();

   line_buf_ctrl #(.IMG_W(IMG_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (lb.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: resident rows as plain integers
   int m_active;
   int m_rf;
   int m_base;
   int m_col;
   int m_err;

   logic [W-1:0] exp_q[$];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_active = 0;
      m_rf     = 0;
      m_base   = 0;
      m_col    = 0;
      m_err    = 0;
      exp_q.delete();
   endfunction

   function automatic void model_step(input logic v, input logic s,
                                      input logic [DATA_W-1:0] d, input logic wd);
      int ptr;
      int rf0;
      logic acc;
      ptr = (m_base + m_rf) % 4;
      rf0 = m_rf;
      acc = v && (m_rf != 4);
      if (acc && s) begin
         if (m_active != 0 && m_col != 0) m_err = 1;
         exp_q.push_back({2'(ptr), COL_W'(0), d});
         m_base   = ptr;
         m_rf     = 0;
         m_col    = 1;
         m_active = 1;
      end else begin
         if (acc && m_active != 0) begin
            exp_q.push_back({2'(ptr), COL_W'(m_col), d});
            if (m_col == IMG_W - 1) begin
               m_col = 0;
               m_rf++;
            end else begin
               m_col++;
            end
         end
         if (wd) begin
            if (rf0 >= 3) begin
               m_base = (m_base + 1) % 4;
               m_rf--;
            end else begin
               m_err = 1;
            end
         end
      end
   endfunction

   task automatic check_outputs();
      logic [W-1:0] e;
      int st;
      st = (m_active == 0) ? int'(IDLE) : ((m_rf >= 3) ? int'(RUN) : int'(FILL));
      chk("in_ready", 32'(lb.in_ready), 32'(m_rf != 4));
      chk("win_valid", 32'(lb.win_valid), 32'(m_active != 0 && m_rf >= 3));
      chk("base", 32'(lb.base), 32'(m_base));
      chk("rows_full", 32'(lb.rows_full), 32'(m_rf));
      chk("err", 32'(lb.err), 32'(m_err));
      chk("state", 32'(lb.dbg_state), 32'(st));
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("wr_en", 32'(lb.wr_en), 32'd1);
         chk("wr_row", 32'(lb.wr_row), 32'(e[W-1 -: 2]));
         chk("wr_col", 32'(lb.wr_col), 32'(e[DATA_W +: COL_W]));
         chk("wr_data", 32'(lb.wr_data), 32'(e[DATA_W-1:0]));
      end else begin
         chk("wr_en", 32'(lb.wr_en), 32'd0);
      end
   endtask

   // driver: called at a falling edge, returns at the next falling edge
   task automatic drive_cycle(input logic v, input logic s, input logic wd);
      logic [DATA_W-1:0] d;
      d = DATA_W'($urandom);
      check_outputs();
      lb.in_valid = v;
      lb.in_sof   = s;
      lb.in_data  = d;
      lb.win_done = wd;
      model_step(v, s, d, wd);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_pixels(input int n, input logic wd_on_last);
      for (int i = 0; i < n; i++) begin
         drive_cycle(1'b1, 1'b0, wd_on_last && (i == n - 1));
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_wr_en"}, 32'(lb.wr_en), 32'd0);
      chk({tag, "_wr_row"}, 32'(lb.wr_row), 32'd0);
      chk({tag, "_wr_col"}, 32'(lb.wr_col), 32'd0);
      chk({tag, "_wr_data"}, 32'(lb.wr_data), 32'd0);
      chk({tag, "_in_ready"}, 32'(lb.in_ready), 32'd1);
      chk({tag, "_base"}, 32'(lb.base), 32'd0);
      chk({tag, "_rows_full"}, 32'(lb.rows_full), 32'd0);
      chk({tag, "_win_valid"}, 32'(lb.win_valid), 32'd0);
      chk({tag, "_err"}, 32'(lb.err), 32'd0);
   endtask

   initial begin
      rst_n       = 1'b0;
      lb.in_valid = 1'b0;
      lb.in_sof   = 1'b0;
      lb.in_data  = '0;
      lb.win_done = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_values("rst");
      rst_n = 1'b1;

      // non-SOF pixels in IDLE are discarded
      send_pixels(3, 1'b0);
      chk("idle_rows_full", 32'(lb.rows_full), 32'd0);

      // fill three rows
      drive_cycle(1'b1, 1'b1, 1'b0);
      send_pixels(3 * IMG_W - 1, 1'b0);
      chk("fill_win_valid", 32'(lb.win_valid), 32'd1);
      chk("fill_base", 32'(lb.base), 32'd0);

      // fourth row then stall with valid held
      send_pixels(IMG_W, 1'b0);
      send_pixels(4, 1'b0);
      chk("full_rows_full", 32'(lb.rows_full), 32'd4);
      chk("full_in_ready", 32'(lb.in_ready), 32'd0);
      drive_cycle(1'b1, 1'b0, 1'b1);
      chk("release_base", 32'(lb.base), 32'd1);
      chk("release_rows_full", 32'(lb.rows_full), 32'd3);
      chk("release_in_ready", 32'(lb.in_ready), 32'd1);

      // win_done aligned with row completion, long enough for base and wr_row to wrap
      for (int r = 0; r < 9; r++) send_pixels(IMG_W, 1'b1);
      chk("aligned_rows_full", 32'(lb.rows_full), 32'd3);
      chk("aligned_base", 32'(lb.base), 32'd2);

      // protocol errors
      drive_cycle(1'b1, 1'b1, 1'b0);
      send_pixels(IMG_W - 1, 1'b0);
      chk("err_pre_rows_full", 32'(lb.rows_full), 32'd1);
      chk("err_pre", 32'(lb.err), 32'd0);
      drive_cycle(1'b0, 1'b0, 1'b1);
      chk("err_wd_low", 32'(lb.err), 32'd1);
      send_pixels(5, 1'b0);
      drive_cycle(1'b1, 1'b1, 1'b0);
      chk("sof_mid_rows_full", 32'(lb.rows_full), 32'd0);
      chk("sof_mid_err", 32'(lb.err), 32'd1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         drive_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 299) == 0,
                     $urandom_range(0, 39) == 0);
      end
      drive_cycle(1'b0, 1'b0, 1'b0);

      // reset mid-row with valid held
      drive_cycle(1'b1, 1'b1, 1'b0);
      send_pixels(7, 1'b0);
      check_outputs();
      lb.in_valid = 1'b1;
      lb.in_sof   = 1'b0;
      lb.win_done = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_values("async_rst");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("rst_hold_wr_en", 32'(lb.wr_en), 32'd0);
      rst_n = 1'b1;
      send_pixels(5, 1'b0);
      drive_cycle(1'b1, 1'b1, 1'b0);
      send_pixels(3, 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b0);
      check_outputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
